dma_memory_to_packet_prefetch: RTL and testbench

//  Parametrised successor DMA engine: reads LENGTH bytes from ADDRESS, emits tagged byte packet.

---
 rtl/dma_memory_to_packet_prefetch_if.sv | 51 +++++
 rtl/dma_memory_to_packet_prefetch.sv | 199 +++++++++++++++++++
 tb/tb_dma_memory_to_packet_prefetch.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_memory_to_packet_prefetch_if.sv
// Bus bundle for dma_memory_to_packet_prefetch: start request, status, byte packet stream and memory port.
// master = DMA engine side, slave = environment (arbiter, TX path, controller).
interface dma_memory_to_packet_prefetch_if #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
);
  logic                  enable_valid;
  logic [ADDR_WIDTH-1:0] enable_address;
  logic [LEN_WIDTH-1:0]  enable_length;
  logic                  busy;
  logic                  done_;
  logic                  done_error;

  logic                  output_packet_valid;
  logic                  output_packet_ready;
  logic [7:0]            output_packet_data;
  logic                  output_packet_last;

  logic                  memory_valid;
  logic                  memory_ready;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic                  memory_write;
  logic [WORD_WIDTH-1:0] memory_write_data;
  logic                  memory_response_valid;
  logic [WORD_WIDTH-1:0] memory_response_read_data;
  logic                  memory_response_error;
  logic                  memory_response_ready;

  modport master (
    input  enable_valid, enable_address, enable_length,
    output busy, done_, done_error,
    output output_packet_valid, output_packet_data, output_packet_last,
    input  output_packet_ready,
    output memory_valid, memory_address, memory_write, memory_write_data,
    input  memory_ready,
    input  memory_response_valid, memory_response_read_data, memory_response_error,
    output memory_response_ready
  );

  modport slave (
    output enable_valid, enable_address, enable_length,
    input  busy, done_, done_error,
    input  output_packet_valid, output_packet_data, output_packet_last,
    output output_packet_ready,
    input  memory_valid, memory_address, memory_write, memory_write_data,
    output memory_ready,
    output memory_response_valid, memory_response_read_data, memory_response_error,
    input  memory_response_ready
  );
endinterface

// File: rtl/dma_memory_to_packet_prefetch.sv
// Memory-to-packet DMA: [HEADER_TAG][length MSB first][payload], payload fed from a word prefetch buffer.
// Define DMA_M2P_CHECKSUM_EN to append a mod-256 payload sum byte that carries last/done_.
module dma_memory_to_packet_prefetch #(
  parameter int         WORD_WIDTH     = 32,
  parameter int         ADDR_WIDTH     = 32,
  parameter int         LEN_WIDTH      = 16,
  parameter logic [7:0] HEADER_TAG     = 8'h44,
  parameter int         PREFETCH_DEPTH = 2
) (
  input logic                             clock,
  input logic                             clear,
  dma_memory_to_packet_prefetch_if.master bus
);
  localparam int BYTES     = WORD_WIDTH / 8;
  localparam int OFF_W     = $clog2(BYTES);
  localparam int HDR_BYTES = LEN_WIDTH / 8;
  localparam int HIDX_W    = $clog2(HDR_BYTES + 1);
  localparam int PTR_W     = $clog2(PREFETCH_DEPTH);
  localparam int CNT_W     = $clog2(PREFETCH_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECKSUM} state_t;
  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  words_to_fetch;
  logic [LEN_WIDTH-1:0]  words_init;
  logic [LEN_WIDTH:0]    span;
  logic [OFF_W-1:0]      lane;
  logic [HIDX_W-1:0]     hdr_idx;
  logic [WORD_WIDTH-1:0] buf_mem [PREFETCH_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      occupied;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W:0]        inflight;
  logic                  err_flag;
`ifdef DMA_M2P_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic       start;
  logic       mem_req;
  logic       mem_fire;
  logic       resp_push;
  logic       out_vld;
  logic       out_fire;
  logic [7:0] out_dat;
  logic       out_last;
  logic       done;
  logic       pop;
  logic       final_pay;
  logic [7:0] hdr_byte;
  logic [7:0] pay_byte;

  assign start = (state == IDLE) && bus.enable_valid && (bus.enable_length != '0);

  // Words spanned by the transfer, counting the leading partial word from a misaligned start.
  assign span = {1'b0, bus.enable_length}
              + (LEN_WIDTH+1)'(bus.enable_address[OFF_W-1:0])
              + (LEN_WIDTH+1)'(BYTES - 1);
  assign words_init = LEN_WIDTH'(span >> OFF_W);

  // Reserving a slot for every outstanding request is what keeps the buffer from overflowing.
  assign inflight  = {1'b0, occupied} + {1'b0, outstanding};
  assign mem_req   = ((state == HEADER) || (state == PAYLOAD))
                  && (words_to_fetch != '0)
                  && (inflight < (CNT_W+1)'(PREFETCH_DEPTH));
  assign mem_fire  = mem_req && bus.memory_ready;
  assign resp_push = bus.memory_response_valid && (state != IDLE) && (outstanding != '0);

  assign hdr_byte  = (hdr_idx == '0) ? HEADER_TAG
                   : 8'(len_reg >> (8 * (HDR_BYTES - int'(hdr_idx))));
  assign pay_byte  = 8'(buf_mem[rd_ptr] >> {lane, 3'b000});
  assign final_pay = (remaining == LEN_WIDTH'(1));

  always_comb begin
    state_next = state;
    out_vld    = 1'b0;
    out_dat    = '0;
    out_last   = 1'b0;
    done       = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = HEADER;
      end
      HEADER: begin
        out_vld = 1'b1;
        out_dat = hdr_byte;
        if (bus.output_packet_ready && (hdr_idx == HIDX_W'(HDR_BYTES))) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        out_vld = (occupied != '0);
        out_dat = pay_byte;
`ifndef DMA_M2P_CHECKSUM_EN
        out_last = out_vld && final_pay;
`endif
        if (out_vld && bus.output_packet_ready) begin
          pop = (lane == OFF_W'(BYTES - 1)) || final_pay;
          if (final_pay) begin
`ifdef DMA_M2P_CHECKSUM_EN
            state_next = CHECKSUM;
`else
            done       = 1'b1;
            state_next = IDLE;
`endif
          end
        end
      end
`ifdef DMA_M2P_CHECKSUM_EN
      CHECKSUM: begin
        out_vld  = 1'b1;
        out_dat  = csum;
        out_last = 1'b1;
        if (bus.output_packet_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign out_fire = out_vld && bus.output_packet_ready;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      fetch_addr     <= '0;
      len_reg        <= '0;
      remaining      <= '0;
      words_to_fetch <= '0;
      lane           <= '0;
      hdr_idx        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occupied       <= '0;
      outstanding    <= '0;
      err_flag       <= 1'b0;
`ifdef DMA_M2P_CHECKSUM_EN
      csum           <= '0;
`endif
      for (int i = 0; i < PREFETCH_DEPTH; i++) buf_mem[i] <= '0;
    end else begin
      if (start) begin
        fetch_addr     <= bus.enable_address & ~ADDR_WIDTH'(BYTES - 1);
        len_reg        <= bus.enable_length;
        remaining      <= bus.enable_length;
        words_to_fetch <= words_init;
        lane           <= bus.enable_address[OFF_W-1:0];
        hdr_idx        <= '0;
        err_flag       <= 1'b0;
`ifdef DMA_M2P_CHECKSUM_EN
        csum           <= '0;
`endif
      end
      if ((state == HEADER) && out_fire) hdr_idx <= hdr_idx + 1'b1;
      if (mem_fire) begin
        fetch_addr     <= fetch_addr + ADDR_WIDTH'(BYTES);
        words_to_fetch <= words_to_fetch - 1'b1;
      end
      outstanding <= outstanding + CNT_W'(mem_fire) - CNT_W'(resp_push);
      // Errored reads still occupy their slot so the byte stream keeps its shape.
      if (resp_push) begin
        buf_mem[wr_ptr] <= bus.memory_response_error ? '0 : bus.memory_response_read_data;
        wr_ptr          <= wr_ptr + 1'b1;
        if (bus.memory_response_error) err_flag <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occupied <= occupied + CNT_W'(resp_push) - CNT_W'(pop);
      if ((state == PAYLOAD) && out_fire) begin
        remaining <= remaining - 1'b1;
        lane      <= pop ? '0 : lane + 1'b1;
`ifdef DMA_M2P_CHECKSUM_EN
        csum      <= csum + pay_byte;
`endif
      end
    end
  end

  assign bus.busy                  = (state != IDLE);
  assign bus.done_                 = done;
  assign bus.done_error            = done && err_flag;
  assign bus.output_packet_valid   = out_vld;
  assign bus.output_packet_data    = out_dat;
  assign bus.output_packet_last    = out_last;
  assign bus.memory_valid          = mem_req;
  assign bus.memory_address        = mem_req ? fetch_addr : '0;
  assign bus.memory_write          = 1'b0;
  assign bus.memory_write_data     = '0;
  assign bus.memory_response_ready = 1'b1;
endmodule

// File: tb/tb_dma_memory_to_packet_prefetch.sv
// Randomised bench for dma_memory_to_packet_prefetch against a byte-level packet model.
`timescale 1ns/1ps
module tb_dma_memory_to_packet_prefetch;
  localparam int WW = 32, AW = 32, LW = 16, DEPTH = 2, HDR = LW / 8;

  logic clock = 1'b0;
  logic clear = 1'b1;

  dma_memory_to_packet_prefetch_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  dma_memory_to_packet_prefetch #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
    .HEADER_TAG(8'h44), .PREFETCH_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          ts;
  } req_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [31:0] mem [logic [31:0]];
  bit          err_map [logic [31:0]];
  req_t        req_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] req_log[$];
  logic        exp_err;
  logic        last_err;
  logic [31:0] job_addr;
  int          job_len;
  int          byte_pos, reqs, popped;
  bit          starting = 1'b0;
  int          out_mode = 0, mem_delay = 0, resp_lat_max = 0, mem_wait = 0;
  bit          prev_out_stall = 1'b0, prev_mem_stall = 1'b0;
  logic [7:0]  prev_out_dat;
  logic [31:0] prev_mem_addr;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC3A5_5A3C ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [63:0] got_at(input int i);
    if (i < got_q.size()) return 64'(got_q[i]);
    return 64'hDEAD;
  endfunction

  // Response side and ready generation, driven just after each rising edge.
  always @(posedge clock) begin
    #1;
    if (clear) begin
      bus.output_packet_ready   = 1'b0;
      bus.memory_ready          = 1'b0;
      bus.memory_response_valid = 1'b0;
    end else begin
      case (out_mode)
        0:       bus.output_packet_ready = 1'b1;
        1:       bus.output_packet_ready = ~bus.output_packet_ready;
        default: bus.output_packet_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (bus.memory_valid) begin
        if (mem_wait >= mem_delay) begin
          bus.memory_ready = 1'b1;
          mem_wait = 0;
        end else begin
          bus.memory_ready = 1'b0;
          mem_wait++;
        end
      end else begin
        bus.memory_ready = 1'b0;
        mem_wait = 0;
      end
      bus.memory_response_valid     = 1'b0;
      bus.memory_response_read_data = '0;
      bus.memory_response_error     = 1'b0;
      if (req_q.size() > 0 && cyc >= req_q[0].ts) begin
        req_t r;
        r = req_q.pop_front();
        bus.memory_response_valid     = 1'b1;
        bus.memory_response_error     = err_map.exists(r.addr);
        bus.memory_response_read_data = err_map.exists(r.addr) ? $urandom : word_at(r.addr);
      end
    end
  end

  // Single compare process: everything observable is checked against the model on the falling edge.
  always @(negedge clock) begin
    if (!clear) begin
      cyc++;
      chk("const_outs", {bus.memory_write, bus.memory_write_data, bus.memory_response_ready}, 64'h1);
      if (!starting) begin
        if (exp_q.size() != 0) chk("busy_active", bus.busy, 1);
        else                   chk("busy_idle", bus.busy, 0);
      end
      if (prev_out_stall) begin
        chk("out_hold_vld", bus.output_packet_valid, 1);
        chk("out_hold_dat", bus.output_packet_data, prev_out_dat);
      end
      if (prev_mem_stall) begin
        chk("mem_hold_vld", bus.memory_valid, 1);
        chk("mem_hold_addr", bus.memory_address, prev_mem_addr);
      end
      if (bus.output_packet_valid && bus.output_packet_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", bus.output_packet_valid, 0);
        end else begin
          logic [7:0] e;
          int i;
          logic [31:0] a;
          e = exp_q.pop_front();
          chk("byte_data", bus.output_packet_data, e);
          chk("byte_last", bus.output_packet_last, exp_q.size() == 0);
          chk("done_pulse", bus.done_, exp_q.size() == 0);
          if (exp_q.size() == 0) begin
            chk("done_error", bus.done_error, exp_err);
            last_err = bus.done_error;
          end
          got_q.push_back(bus.output_packet_data);
          i = byte_pos - 1 - HDR;
          if (i >= 0 && i < job_len) begin
            a = job_addr + 32'(i);
            if (a[1:0] == 2'b11 || i == job_len - 1) popped++;
          end
          byte_pos++;
        end
      end else if (bus.done_) begin
        chk("done_stray", bus.done_, 0);
      end
      if (bus.memory_valid && bus.memory_ready) begin
        if (exp_addr_q.size() == 0) chk("extra_read", bus.memory_valid, 0);
        else                        chk("read_addr", bus.memory_address, exp_addr_q.pop_front());
        req_q.push_back('{addr: bus.memory_address, ts: cyc + int'($urandom_range(0, resp_lat_max))});
        req_log.push_back(bus.memory_address);
        reqs++;
        chk("prefetch_bound", (reqs - popped) <= DEPTH, 1);
      end
      prev_out_stall = bus.output_packet_valid && !bus.output_packet_ready;
      prev_out_dat   = bus.output_packet_data;
      prev_mem_stall = bus.memory_valid && !bus.memory_ready;
      prev_mem_addr  = bus.memory_address;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, {bus.done_, bus.done_error}, 0);
    chk({tag, "_out"}, {bus.output_packet_valid, bus.output_packet_data, bus.output_packet_last}, 0);
    chk({tag, "_mem"}, {bus.memory_valid, bus.memory_address, bus.memory_write}, 0);
    chk({tag, "_wdata"}, bus.memory_write_data, 0);
    chk({tag, "_rsp_rdy"}, bus.memory_response_ready, 1);
  endtask

  task automatic pulse_clear(input bit check);
    @(negedge clock);
    #2 clear = 1'b1;
    #1;
    if (check) check_reset_outputs("clear");
    req_q.delete();
    exp_q.delete();
    exp_addr_q.delete();
    prev_out_stall = 1'b0;
    prev_mem_stall = 1'b0;
    byte_pos = 0; reqs = 0; popped = 0; mem_wait = 0;
    starting = 1'b0;
    bus.enable_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    #2 clear = 1'b0;
  endtask

  task automatic start_job(input logic [31:0] addr, input int len);
    int n;
    logic [31:0] a, w, base;
    logic [7:0] b, sum;
    int nwords;
    n = 0;
    while (bus.busy && n < 4000) begin
      @(posedge clock);
      n++;
    end
    if (bus.busy) begin
      chk("idle_wait", bus.busy, 0);
      pulse_clear(0);
    end
    @(posedge clock);
    #1;
    starting = 1'b1;
    exp_q.delete(); exp_addr_q.delete(); got_q.delete(); req_log.delete();
    byte_pos = 0; reqs = 0; popped = 0; exp_err = 1'b0; last_err = 1'b0;
    job_addr = addr; job_len = len;
    if (len != 0) begin
      exp_q.push_back(8'h44);
      exp_q.push_back(len[15:8]);
      exp_q.push_back(len[7:0]);
      sum = 8'h00;
      for (int i = 0; i < len; i++) begin
        a = addr + 32'(i);
        w = a & ~32'h3;
        if (err_map.exists(w)) begin
          b = 8'h00;
          exp_err = 1'b1;
        end else begin
          w = word_at(w);
          b = w[8*a[1:0] +: 8];
        end
        exp_q.push_back(b);
        sum = sum + b;
      end
`ifdef DMA_M2P_CHECKSUM_EN
      exp_q.push_back(sum);
`endif
      nwords = (int'(addr[1:0]) + len + 3) / 4;
      base = addr & ~32'h3;
      for (int k = 0; k < nwords; k++) exp_addr_q.push_back(base + 32'(4 * k));
    end
    bus.enable_valid   = 1'b1;
    bus.enable_address = addr;
    bus.enable_length  = 16'(len);
    @(posedge clock);
    #1;
    bus.enable_valid   = 1'b0;
    bus.enable_address = $urandom;
    bus.enable_length  = 16'($urandom);
    starting = 1'b0;
    if (len != 0) begin
      @(negedge clock);
      chk("first_hdr_vld", bus.output_packet_valid, 1);
      chk("first_hdr_dat", bus.output_packet_data, 8'h44);
    end
  endtask

  task automatic wait_job();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 4000) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0 || bus.busy) begin
      chk("job_timeout", exp_q.size(), 0);
      pulse_clear(0);
    end
    chk("reads_issued", exp_addr_q.size(), 0);
  endtask

  task automatic run_job(input logic [31:0] addr, input int len);
    start_job(addr, len);
    wait_job();
  endtask

  logic [7:0] t1 [7] = '{8'h44, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable_valid = 1'b0;
    bus.enable_address = '0;
    bus.enable_length = '0;
    bus.output_packet_ready = 1'b0;
    bus.memory_ready = 1'b0;
    bus.memory_response_valid = 1'b0;
    bus.memory_response_read_data = '0;
    bus.memory_response_error = 1'b0;
    #2 check_reset_outputs("reset");
    #20;
    @(negedge clock);
    #2 clear = 1'b0;

    // Aligned four-byte job.
    mem[32'h100] = 32'h4433_2211;
    run_job(32'h100, 4);
    chk("t1_count", got_q.size(), 7);
    for (int i = 0; i < 7; i++) chk("t1_byte", got_at(i), 64'(t1[i]));
    chk("t1_reads", req_log.size(), 1);

    // Misaligned start straddling two words.
    mem[32'h100] = 32'hAABB_CCDD;
    mem[32'h104] = 32'h1122_3344;
    run_job(32'h103, 3);
    chk("t2_b0", got_at(3), 64'hAA);
    chk("t2_b1", got_at(4), 64'h44);
    chk("t2_b2", got_at(5), 64'h33);
    chk("t2_reads", req_log.size(), 2);
    if (req_log.size() == 2) begin
      chk("t2_addr0", req_log[0], 32'h100);
      chk("t2_addr1", req_log[1], 32'h104);
    end

    // Output backpressure toggling, slow memory acceptance.
    out_mode = 1; mem_delay = 3; resp_lat_max = 2;
    run_job(32'h202, 16);
    chk("t3_count", got_q.size(), 19 + (exp_q.size()));

    // Second word errors.
    out_mode = 0; mem_delay = 0; resp_lat_max = 0;
    err_map[32'h304] = 1'b1;
    run_job(32'h300, 8);
    for (int i = 7; i < 11; i++) chk("t4_zero", got_at(i), 64'h00);
    chk("t4_err", last_err, 1);
    err_map.delete();

    // Abort mid-payload, then a one-byte job.
    start_job(32'h600, 40);
    begin
      int n;
      n = 0;
      while (byte_pos < 6 && n < 500) begin
        @(posedge clock);
        n++;
      end
      chk("t5_reached_payload", byte_pos >= 6, 1);
    end
    pulse_clear(1);
    run_job(32'h701, 1);
    chk("t5_count", got_q.size(), 1 + HDR + 1
`ifdef DMA_M2P_CHECKSUM_EN
      + 1
`endif
    );

    // Zero length is ignored.
    start_job(32'h800, 0);
    repeat (3) @(posedge clock);
    #1 chk("t6_len0_idle", bus.busy, 0);

`ifdef DMA_M2P_CHECKSUM_EN
    mem[32'h900] = 32'h0000_FF01;
    run_job(32'h900, 2);
    chk("t6_cks_count", got_q.size(), 6);
    chk("t6_cks_byte", got_at(5), 64'h00);
`endif

    // Address wrap at the top of memory.
    run_job(32'hFFFF_FFFA, 12);
    chk("wrap_reads", req_log.size(), 4);

    for (int j = 0; j < 25; j++) begin
      logic [31:0] ra;
      int rl;
      ra = $urandom;
      rl = int'($urandom_range(1, 40));
      out_mode = int'($urandom_range(0, 2));
      mem_delay = int'($urandom_range(0, 3));
      resp_lat_max = int'($urandom_range(0, 4));
      err_map.delete();
      if ($urandom_range(0, 3) == 0) err_map[(ra + 32'($urandom_range(0, rl - 1))) & ~32'h3] = 1'b1;
      run_job(ra, rl);
    end

    repeat (4) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
